// File: rtl/bcp_core.sv
// Boolean constraint propagation scan engine: walks a clause range, evaluates each
// clause against the variable state, pushes unit implications and stops on the first conflict.
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module bcp_core (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [`MAX_CLAUSES_BITS-1:0]     start_clause,
    input  logic [`MAX_CLAUSES_BITS-1:0]     end_clause,
    output logic                             clause_rd_en,
    output logic [`MAX_CLAUSES_BITS-1:0]     clause_rd_addr,
    input  logic [3*(`MAX_VARS_BITS+2)-1:0]  clause_rd_data,
    output logic [`MAX_VARS_BITS-1:0]        vs_var0,
    output logic [`MAX_VARS_BITS-1:0]        vs_var1,
    output logic [`MAX_VARS_BITS-1:0]        vs_var2,
    input  logic                             vs_val0,
    input  logic                             vs_val1,
    input  logic                             vs_val2,
    input  logic                             vs_unassigned0,
    input  logic                             vs_unassigned1,
    input  logic                             vs_unassigned2,
    output logic                             push_imply,
    output logic [`MAX_VARS_BITS-1:0]        var_in_imply,
    output logic                             val_in_imply,
    input  logic                             full_imply,
    output logic                             bcp_busy,
    output logic                             bcp_done,
    output logic                             conflict,
    output logic [`MAX_CLAUSES_BITS-1:0]     bcp_clause_idx
);

    localparam int unsigned CB = `MAX_CLAUSES_BITS;
    localparam int unsigned VB = `MAX_VARS_BITS;
    localparam int unsigned SW = VB + 2;

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    state_t          state, state_nx;
    logic [CB-1:0]   cur, cur_nx;
    logic [CB-1:0]   end_q, end_nx;
    logic [CB-1:0]   idx_nx;
    logic            conflict_nx;
    logic [3*SW-1:0] clause_q, clause_cur;
    logic            eval_hold;

    logic [2:0]      s_valid, s_sign, val_a, un_a, lit_true, lit_un;
    logic [VB-1:0]   s_var [3];
    logic [1:0]      n_un;
    logic            is_conf, is_unit, unit_sign;
    logic [VB-1:0]   unit_var;

    assign val_a = {vs_val2, vs_val1, vs_val0};
    assign un_a  = {vs_unassigned2, vs_unassigned1, vs_unassigned0};

    // Read data is only valid in the first EVAL cycle; a stalled EVAL reuses the captured copy.
    always_comb begin
        clause_cur = eval_hold ? clause_q : clause_rd_data;
        unit_var   = '0;
        unit_sign  = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            s_valid[i]  = clause_cur[i*SW + SW - 1];
            s_sign[i]   = clause_cur[i*SW + VB];
            s_var[i]    = clause_cur[i*SW +: VB];
            lit_true[i] = s_valid[i] & ~un_a[i] & (val_a[i] ^ s_sign[i]);
            lit_un[i]   = s_valid[i] & un_a[i];
            if (lit_un[i]) begin
                unit_var  = s_var[i];
                unit_sign = s_sign[i];
            end
        end
        n_un    = 2'(lit_un[0]) + 2'(lit_un[1]) + 2'(lit_un[2]);
        is_conf = ~(|lit_true) && (n_un == 2'd0);
        is_unit = ~(|lit_true) && (n_un == 2'd1);
    end

    assign vs_var0 = s_var[0];
    assign vs_var1 = s_var[1];
    assign vs_var2 = s_var[2];

    assign clause_rd_en   = (state == FETCH);
    assign clause_rd_addr = clause_rd_en ? cur : '0;
    assign push_imply     = (state == EVAL) && is_unit && !full_imply;
    assign var_in_imply   = push_imply ? unit_var : '0;
    assign val_in_imply   = push_imply & ~unit_sign;
    assign bcp_busy       = (state != IDLE);
    assign bcp_done       = (state == DONE);

    always_comb begin
        state_nx    = state;
        cur_nx      = cur;
        end_nx      = end_q;
        conflict_nx = conflict;
        idx_nx      = bcp_clause_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    cur_nx      = start_clause;
                    end_nx      = end_clause;
                    conflict_nx = 1'b0;
                    idx_nx      = '0;
                    state_nx    = (start_clause > end_clause) ? DONE : FETCH;
                end
            end
            FETCH: state_nx = EVAL;
            EVAL: begin
                if (is_conf) begin
                    conflict_nx = 1'b1;
                    idx_nx      = cur;
                    state_nx    = DONE;
                end else if (is_unit && full_imply) begin
                    state_nx = EVAL;
                end else if (cur == end_q) begin
                    state_nx = DONE;
                end else begin
                    cur_nx   = cur + 1'b1;
                    state_nx = FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cur            <= '0;
            end_q          <= '0;
            conflict       <= 1'b0;
            bcp_clause_idx <= '0;
            clause_q       <= '0;
            eval_hold      <= 1'b0;
        end else begin
            state          <= state_nx;
            cur            <= cur_nx;
            end_q          <= end_nx;
            conflict       <= conflict_nx;
            bcp_clause_idx <= idx_nx;
            clause_q       <= clause_cur;
            eval_hold      <= (state == EVAL) && (state_nx == EVAL);
        end
    end

endmodule
